// File: rtl/fft_pkg.sv
// Shared FFT stream types and constants: sample layout, bin/magnitude widths,
// and a signed-square helper used by the magnitude stages.
package fft_pkg;

    localparam int N_BINS = 4096;
    localparam int DATA_W = 16;
    localparam int HALF_W = DATA_W / 2;
    localparam int BIN_W  = $clog2(N_BINS);
    localparam int MAG_W  = DATA_W;

    typedef logic [BIN_W-1:0] bin_t;

    typedef struct packed {
        logic signed [HALF_W-1:0] im;
        logic signed [HALF_W-1:0] re;
    } fft_sample_t;

    // The square of a signed half-word never exceeds 2^(2*HALF_W-2), so one bit is dropped.
    function automatic logic [2*HALF_W-2:0] sq_signed(input logic signed [HALF_W-1:0] x);
        logic signed [2*HALF_W-1:0] p;
        p = x * x;
        return p[2*HALF_W-2:0];
    endfunction

endpackage

// File: rtl/fft_peak_detector_if.sv
// AXI-stream style beat interface carrying FFT bins from the FFT wrapper.
interface fft_peak_detector_if #(
    parameter int DATA_W = fft_pkg::DATA_W
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/mag_sq.sv
// One-stage registered squared magnitude re^2 + im^2 with a valid passthrough.
module mag_sq
    import fft_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_i,
    input  fft_sample_t      sample_i,
    output logic             valid_o,
    output logic [MAG_W-1:0] mag_o
);

    logic             valid_q;
    logic [MAG_W-1:0] mag_q;

    // Register the sum; the magnitude only moves on valid beats so it holds across gaps.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            mag_q   <= {MAG_W{1'b0}};
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                mag_q <= {1'b0, sq_signed(sample_i.re)} + {1'b0, sq_signed(sample_i.im)};
            end else begin
                mag_q <= mag_q;
            end
        end
    end

    assign valid_o = valid_q;
    assign mag_o   = mag_q;

endmodule

// File: rtl/fft_peak_detector.sv
// Per-frame peak search over the lower half-spectrum of an FFT output stream,
// with framing checks and a threshold-qualified note-present flag.
module fft_peak_detector
    import fft_pkg::*;
#(
    parameter int N_BINS  = fft_pkg::N_BINS,
    parameter int DATA_W  = fft_pkg::DATA_W,
    parameter int MIN_BIN = 1
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    fft_peak_detector_if.slave          s_axis,
    input  logic [DATA_W-1:0]           threshold,
    output logic [$clog2(N_BINS)-1:0]   peak_bin,
    output logic [DATA_W-1:0]           peak_mag,
    output logic                        note_present,
    output logic                        peak_valid,
    output logic                        frame_err
);

    localparam int BW = $clog2(N_BINS);
    localparam int MW = DATA_W;

    logic          tready_q;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          accept_s, at_end_s, err_s, elig_s;
    fft_sample_t   sample_s;

    logic          s1_valid_s;
    logic [MW-1:0] s1_mag_s;
    logic [BW-1:0] s1_bin_q;
    logic          s1_first_q, s1_last_q, s1_elig_q, s1_err_q;

    logic [MW-1:0] max_mag_q, max_mag_d, base_mag_s, new_mag_s;
    logic [BW-1:0] max_bin_q, max_bin_d, base_bin_s, new_bin_s;
    logic [BW-1:0] peak_bin_q, peak_bin_d;
    logic [MW-1:0] peak_mag_q, peak_mag_d;
    logic          note_q, note_d, pvalid_q, pvalid_d, ferr_q, ferr_d;

    assign accept_s      = s_axis.tvalid && tready_q;
    assign sample_s      = s_axis.tdata;
    assign s_axis.tready = tready_q;

    // Beat classification and bin counter; tlast and the final bin must coincide.
    always_comb begin
        at_end_s = (cnt_q == BW'(N_BINS - 1));
        err_s    = s_axis.tlast ^ at_end_s;
        elig_s   = (cnt_q >= BW'(MIN_BIN)) && (cnt_q < BW'(N_BINS / 2));
        cnt_d    = cnt_q;
        if (accept_s) begin
            cnt_d = (s_axis.tlast || at_end_s) ? {BW{1'b0}} : cnt_q + BW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Ready comes up on the first edge after reset and stays up; counter advances on accepts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tready_q <= 1'b0;
            cnt_q    <= {BW{1'b0}};
        end else begin
            tready_q <= 1'b1;
            cnt_q    <= cnt_d;
        end
    end

    mag_sq u_mag_sq (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .valid_i  (accept_s),
        .sample_i (sample_s),
        .valid_o  (s1_valid_s),
        .mag_o    (s1_mag_s)
    );

    // Stage-1 sideband flags travel alongside the registered magnitude.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_bin_q   <= {BW{1'b0}};
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_elig_q  <= 1'b0;
            s1_err_q   <= 1'b0;
        end else if (accept_s) begin
            s1_bin_q   <= cnt_q;
            s1_first_q <= (cnt_q == {BW{1'b0}});
            s1_last_q  <= s_axis.tlast && at_end_s;
            s1_elig_q  <= elig_s;
            s1_err_q   <= err_s;
        end else begin
            s1_bin_q   <= s1_bin_q;
            s1_first_q <= s1_first_q;
            s1_last_q  <= s1_last_q;
            s1_elig_q  <= s1_elig_q;
            s1_err_q   <= s1_err_q;
        end
    end

    // Stage 2: the first flag reseeds the max so back-to-back frames need no idle cycle.
    always_comb begin
        base_mag_s = s1_first_q ? {MW{1'b0}} : max_mag_q;
        base_bin_s = s1_first_q ? BW'(MIN_BIN) : max_bin_q;
        if (s1_elig_q && (s1_mag_s > base_mag_s)) begin
            new_mag_s = s1_mag_s;
            new_bin_s = s1_bin_q;
        end else begin
            new_mag_s = base_mag_s;
            new_bin_s = base_bin_s;
        end

        max_mag_d  = max_mag_q;
        max_bin_d  = max_bin_q;
        peak_bin_d = peak_bin_q;
        peak_mag_d = peak_mag_q;
        note_d     = note_q;
        pvalid_d   = 1'b0;
        ferr_d     = 1'b0;
        if (s1_valid_s) begin
            max_mag_d = new_mag_s;
            max_bin_d = new_bin_s;
            if (s1_last_q) begin
                peak_bin_d = new_bin_s;
                peak_mag_d = new_mag_s;
                note_d     = (new_mag_s > threshold);
                pvalid_d   = 1'b1;
            end else if (s1_err_q) begin
                ferr_d = 1'b1;
            end else begin
                pvalid_d = 1'b0;
            end
        end else begin
            max_mag_d = max_mag_q;
        end
    end

    // Running max and result registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            max_mag_q  <= {MW{1'b0}};
            max_bin_q  <= {BW{1'b0}};
            peak_bin_q <= {BW{1'b0}};
            peak_mag_q <= {MW{1'b0}};
            note_q     <= 1'b0;
            pvalid_q   <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            max_mag_q  <= max_mag_d;
            max_bin_q  <= max_bin_d;
            peak_bin_q <= peak_bin_d;
            peak_mag_q <= peak_mag_d;
            note_q     <= note_d;
            pvalid_q   <= pvalid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign peak_bin     = peak_bin_q;
    assign peak_mag     = peak_mag_q;
    assign note_present = note_q;
    assign peak_valid   = pvalid_q;
    assign frame_err    = ferr_q;

endmodule
